axi_lite_mem_slave: RTL

AXI_LITE_MEM_SLAVE -- requirements
Module: axi_lite_mem_slave

---
 rtl/axi_lite_pkg.sv | 32 +++
 rtl/axi_lite_mem_array.sv | 42 ++++
 rtl/axi_lite_mem_slave.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg
// Purpose: shared types, widths and response codes for the AXI4-Lite
// memory responder (axi_lite_mem_slave) and its storage array.
// Contents: BUFFER_SIZE, ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH, addr_t, data_t,
// strb_t, resp_t, RESP_* codes, state_type FSM encoding.
package axi_lite_pkg;

  localparam int BUFFER_SIZE = 4096;
  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int STRB_WIDTH  = DATA_WIDTH / 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;
  typedef logic [1:0]            resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP
  } state_type;

endpackage

// File: rtl/axi_lite_mem_array.sv
// axi_lite_mem_array
// Purpose: storage for the AXI4-Lite responder; DEPTH words of data_t,
// one synchronous write port and one registered read port (block RAM style).
// Contents are never reset.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write word index
//   i_wdata  in   write data
//   i_re     in   read enable (loads o_rdata on the next rising edge)
//   i_raddr  in   read word index
//   o_rdata  out  registered read data, held while i_re is low
module axi_lite_mem_array
  import axi_lite_pkg::*;
#(
  parameter int DEPTH = BUFFER_SIZE,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  data_t            i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output data_t            o_rdata
);

  data_t r_mem [DEPTH];
  data_t r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave
// Purpose: AXI4-Lite responder backed by a MEM_DEPTH x DATA_WIDTH memory,
// one transaction at a time. Reads: IDLE -> RADDR -> RDATA. Writes:
// IDLE -> WADDR -> WDATA -> WRESP. Addresses >= MEM_DEPTH answer DECERR
// (writes dropped, read data 0). A write stores wdata only when wstrb[0]=1.
// Optional build macro: AXI_LITE_SLV_RR_ARB_EN -- when defined, simultaneous
// arvalid/awvalid in IDLE alternate between read and write using a
// last-served flag; otherwise reads always win.
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   araddr/arvalid/arready       read address channel
//   rdata/rresp/rvalid/rready    read data channel
//   awaddr/awvalid/awready       write address channel
//   wdata/wstrb/wvalid/wready    write data channel
//   bresp/bvalid/bready          write response channel
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int MEM_DEPTH = BUFFER_SIZE
) (
  input  logic  aclk,
  input  logic  areset,
  input  addr_t araddr,
  input  logic  arvalid,
  output logic  arready,
  output data_t rdata,
  output resp_t rresp,
  output logic  rvalid,
  input  logic  rready,
  input  addr_t awaddr,
  input  logic  awvalid,
  output logic  awready,
  input  data_t wdata,
  input  strb_t wstrb,
  input  logic  wvalid,
  output logic  wready,
  output resp_t bresp,
  output logic  bvalid,
  input  logic  bready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  state_type r_state, w_state_next;
  addr_t     r_awaddr;
  resp_t     r_rresp, r_bresp;
  logic      r_rd_in_range;

  logic  w_arready, w_rvalid, w_awready, w_wready, w_bvalid;
  logic  w_ar_hs, w_aw_hs, w_w_hs;
  logic  w_ar_in_range, w_aw_in_range;
  logic  w_pick_write;
  logic  w_mem_we;
  data_t w_mem_rdata;
  logic  w_unused;

`ifdef AXI_LITE_SLV_RR_ARB_EN
  // 1 = write was the last winner of a simultaneous request.
  logic r_last_wr;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_last_wr <= 1'b1;
    end else if (r_state == IDLE && arvalid && awvalid) begin
      r_last_wr <= w_pick_write;
    end
  end

  assign w_pick_write = arvalid && awvalid && !r_last_wr;
`else
  assign w_pick_write = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (arvalid && !w_pick_write) begin
          w_state_next = RADDR;
        end else if (awvalid) begin
          w_state_next = WADDR;
        end
      end
      RADDR: begin
        w_arready = 1'b1;
        if (arvalid) w_state_next = RDATA;
      end
      RDATA: begin
        w_rvalid = 1'b1;
        if (rready) w_state_next = IDLE;
      end
      WADDR: begin
        w_awready = 1'b1;
        if (awvalid) w_state_next = WDATA;
      end
      WDATA: begin
        w_wready = 1'b1;
        if (wvalid) w_state_next = WRESP;
      end
      WRESP: begin
        w_bvalid = 1'b1;
        if (bready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_ar_hs       = w_arready && arvalid;
  assign w_aw_hs       = w_awready && awvalid;
  assign w_w_hs        = w_wready && wvalid;
  assign w_ar_in_range = araddr < addr_t'(MEM_DEPTH);
  assign w_aw_in_range = r_awaddr < addr_t'(MEM_DEPTH);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_awaddr      <= '0;
      r_rresp       <= RESP_OKAY;
      r_bresp       <= RESP_OKAY;
      r_rd_in_range <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rresp       <= w_ar_in_range ? RESP_OKAY : RESP_DECERR;
        r_rd_in_range <= w_ar_in_range;
      end
      if (w_aw_hs) begin
        r_awaddr <= awaddr;
      end
      if (w_w_hs) begin
        r_bresp <= w_aw_in_range ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Read port is addressed straight from araddr at the handshake so the
  // registered memory output is ready in the first RDATA cycle, and it only
  // reloads on the next handshake, keeping rdata stable while rready is low.
  assign w_mem_we = w_w_hs && w_aw_in_range && wstrb[0];

  axi_lite_mem_array #(
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk     (aclk),
    .i_we    (w_mem_we),
    .i_waddr (r_awaddr[IDX_W-1:0]),
    .i_wdata (wdata),
    .i_re    (w_ar_hs),
    .i_raddr (araddr[IDX_W-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // Memory output is not reset, so gate it: zero outside RDATA and for
  // out-of-range reads.
  assign rdata   = (r_state == RDATA && r_rd_in_range) ? w_mem_rdata : '0;
  assign rresp   = r_rresp;
  assign bresp   = r_bresp;
  assign arready = w_arready;
  assign rvalid  = w_rvalid;
  assign awready = w_awready;
  assign wready  = w_wready;
  assign bvalid  = w_bvalid;

  // Only wstrb[0] gates a write; the upper strobe bits are ignored.
  assign w_unused = ^wstrb[STRB_WIDTH-1:1];

endmodule
